instr_fetch: RTL and testbench

Instruction fetch and issue unit for the MIPS-subset core. It sits upstream of the main control decoder. It holds the PC, fetches 32-bit instruction words over a req/ack instruction-memory port, and latches each word into an instruction register. It presents the Opcode and field slices to the control decoder and datapath, then computes the next PC from the Jump and Branch signals returned by the decoder and the ALU Zero flag.

---
 rtl/instr_fetch_if.sv | 21 ++
 rtl/instr_fetch.sv | 103 ++++++++++
 tb/tb_instr_fetch.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory req/ack port between the fetch unit (master) and memory (slave).
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch/issue unit: holds PC and IR, fetches one word per instruction over a
// req/ack port, and resolves the next PC from Jump/Branch/Zero when leaving ISSUE.
module instr_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_if.master      imem,
    input  logic               Jump,
    input  logic               Branch,
    input  logic               Zero,
    input  logic               stall,
    output logic               instr_valid,
    output logic [5:0]         Opcode,
    output logic [4:0]         Rs,
    output logic [4:0]         Rt,
    output logic [4:0]         Rd,
    output logic [5:0]         Funct,
    output logic [15:0]        Imm,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4
);

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam logic [31:0] PC_RESET_ALIGNED = PC_RESET & 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_offset;
    logic [31:0] next_pc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET_ALIGNED;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign pc_plus4_w    = pc_q + 32'd4;
    assign branch_offset = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    // Jump has priority, so an unknown Branch cannot disturb a jump target.
    always_comb begin
        next_pc = pc_plus4_w;
        if (Jump) begin
            next_pc = {pc_plus4_w[31:28], ir_q[25:0], 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pc_plus4_w + branch_offset;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            FETCH: begin
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    pc_d    = {next_pc[31:2], 2'b00};
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        imem.imem_req  = (state_q == FETCH);
        imem.imem_addr = pc_q;
        instr_valid    = (state_q == ISSUE);
    end

    assign Opcode   = ir_q[31:26];
    assign Rs       = ir_q[25:21];
    assign Rt       = ir_q[20:16];
    assign Rd       = ir_q[15:11];
    assign Funct    = ir_q[5:0];
    assign Imm      = ir_q[15:0];
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_w;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one unit at PC_RESET=0, one at 0xF000_0020
// for the jump-region and wrap-around sequences.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    instr_fetch_if a_if ();
    instr_fetch_if b_if ();

    logic        a_reset, a_jump, a_branch, a_zero, a_stall;
    logic        a_valid;
    logic [5:0]  a_opcode, a_funct;
    logic [4:0]  a_rs, a_rt, a_rd;
    logic [15:0] a_imm;
    logic [31:0] a_pc, a_pc4;

    logic        b_reset, b_jump, b_branch, b_zero, b_stall;
    logic        b_valid;
    logic [5:0]  b_opcode, b_funct;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic [15:0] b_imm;
    logic [31:0] b_pc, b_pc4;

    instr_fetch #(.PC_RESET(32'h0000_0000)) u_a (
        .clk(clk), .reset(a_reset), .imem(a_if),
        .Jump(a_jump), .Branch(a_branch), .Zero(a_zero), .stall(a_stall),
        .instr_valid(a_valid), .Opcode(a_opcode), .Rs(a_rs), .Rt(a_rt),
        .Rd(a_rd), .Funct(a_funct), .Imm(a_imm), .pc(a_pc), .pc_plus4(a_pc4)
    );

    instr_fetch #(.PC_RESET(32'hF000_0020)) u_b (
        .clk(clk), .reset(b_reset), .imem(b_if),
        .Jump(b_jump), .Branch(b_branch), .Zero(b_zero), .stall(b_stall),
        .instr_valid(b_valid), .Opcode(b_opcode), .Rs(b_rs), .Rt(b_rt),
        .Rd(b_rd), .Funct(b_funct), .Imm(b_imm), .pc(b_pc), .pc_plus4(b_pc4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        a_reset = 1'b1; a_jump = 1'b0; a_branch = 1'b0; a_zero = 1'b0; a_stall = 1'b0;
        a_if.imem_ack = 1'b0; a_if.imem_rdata = '0;
        b_reset = 1'b1; b_jump = 1'b0; b_branch = 1'b0; b_zero = 1'b0; b_stall = 1'b0;
        b_if.imem_ack = 1'b0; b_if.imem_rdata = '0;
        tick();
        tick();
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset state
        chk("rst_req",    32'(a_if.imem_req), 32'd1);
        chk("rst_addr",   a_if.imem_addr, 32'h0000_0000);
        chk("rst_valid",  32'(a_valid), 32'd0);
        chk("rst_opcode", 32'(a_opcode), 32'd0);
        chk("rst_b_addr", b_if.imem_addr, 32'hF000_0020);

        // Back-to-back fetch with ack tied high
        a_if.imem_ack = 1'b1; a_if.imem_rdata = 32'h0000_0020;
        tick();
        chk("seq0_valid", 32'(a_valid), 32'd1);
        chk("seq0_req",   32'(a_if.imem_req), 32'd0);
        chk("seq0_funct", 32'(a_funct), 32'h20);
        chk("seq0_pc",    a_pc, 32'h0);
        chk("seq0_pc4",   a_pc4, 32'h4);
        tick();
        chk("seq1_valid", 32'(a_valid), 32'd0);
        chk("seq1_addr",  a_if.imem_addr, 32'h4);

        // Three wait states at pc=0x4
        a_if.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req",   32'(a_if.imem_req), 32'd1);
            chk("wait_addr",  a_if.imem_addr, 32'h4);
            chk("wait_valid", 32'(a_valid), 32'd0);
        end
        a_if.imem_ack = 1'b1;
        tick();
        chk("wait_ack_valid", 32'(a_valid), 32'd1);
        chk("wait_ack_pc",    a_pc, 32'h4);

        // Ack during ISSUE must not reload ir
        a_if.imem_rdata = 32'hFFFF_FFFF; a_stall = 1'b1;
        tick();
        chk("iss_ack_funct",  32'(a_funct), 32'h20);
        chk("iss_ack_opcode", 32'(a_opcode), 32'h0);
        chk("iss_ack_valid",  32'(a_valid), 32'd1);
        a_if.imem_ack = 1'b0; a_stall = 1'b0; a_if.imem_rdata = 32'h0000_0020;
        tick();
        chk("seq2_addr", a_if.imem_addr, 32'h8);
        a_if.imem_ack = 1'b1;
        tick();
        chk("seq2_pc", a_pc, 32'h8);
        tick();
        chk("seq3_addr", a_if.imem_addr, 32'hC);
        tick();
        tick();
        chk("seq4_addr", a_if.imem_addr, 32'h10);

        // BEQ at 0x10 with Imm=-1: taken loops back to 0x10
        a_if.imem_rdata = 32'h1000_FFFF;
        tick();
        chk("beq_opcode", 32'(a_opcode), 32'h04);
        chk("beq_imm",    32'(a_imm), 32'hFFFF);
        a_branch = 1'b1; a_zero = 1'b1;
        tick();
        chk("beq_taken_addr", a_if.imem_addr, 32'h10);
        tick();
        a_zero = 1'b0;
        tick();
        chk("beq_nt_addr", a_if.imem_addr, 32'h14);

        // Jump from 0x14 back to 0x10
        a_branch = 1'b0;
        a_if.imem_rdata = 32'h0800_0004;
        tick();
        a_jump = 1'b1;
        tick();
        chk("j_addr", a_if.imem_addr, 32'h10);
        a_jump = 1'b0;

        // BEQ Imm=4 taken at 0x10: 0x14 + 0x10
        a_if.imem_rdata = 32'h1000_0004;
        tick();
        chk("beq4_imm", 32'(a_imm), 32'h0004);
        a_branch = 1'b1; a_zero = 1'b1;
        tick();
        chk("beq4_addr", a_if.imem_addr, 32'h24);
        a_branch = 1'b0; a_zero = 1'b0;

        // Stall for 3 ISSUE cycles with unknown decoder inputs
        a_if.imem_rdata = 32'h8C00_0000;
        tick();
        a_stall = 1'b1; a_jump = 1'bx; a_branch = 1'bx; a_zero = 1'bx;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid",  32'(a_valid), 32'd1);
            chk("stall_opcode", 32'(a_opcode), 32'h23);
            chk("stall_pc",     a_pc, 32'h24);
            chk("stall_req",    32'(a_if.imem_req), 32'd0);
        end

        // Reset during stalled ISSUE
        a_reset = 1'b1;
        tick();
        chk("rst_iss_valid", 32'(a_valid), 32'd0);
        chk("rst_iss_pc",    a_pc, 32'h0);
        a_reset = 1'b0; a_stall = 1'b0; a_jump = 1'b0; a_branch = 1'b0; a_zero = 1'b0;

        // Jump to 0x40, then reset during a wait there
        a_if.imem_rdata = 32'h0800_0010;
        tick();
        chk("j40_pc", a_pc, 32'h0);
        a_jump = 1'b1;
        tick();
        chk("j40_addr", a_if.imem_addr, 32'h40);
        a_jump = 1'b0; a_if.imem_ack = 1'b0;
        tick();
        chk("w40_addr", a_if.imem_addr, 32'h40);
        a_reset = 1'b1;
        tick();
        chk("rst_fetch_addr",  a_if.imem_addr, 32'h0);
        chk("rst_fetch_valid", 32'(a_valid), 32'd0);
        chk("rst_fetch_req",   32'(a_if.imem_req), 32'd1);
        a_reset = 1'b0; a_if.imem_ack = 1'b1; a_if.imem_rdata = 32'h0000_0020;
        tick();
        chk("post_rst_valid", 32'(a_valid), 32'd1);
        chk("post_rst_pc",    a_pc, 32'h0);
        a_if.imem_ack = 1'b0;

        // Unit B: jump within the 0xF region, Jump beating a taken branch
        b_if.imem_ack = 1'b1; b_if.imem_rdata = 32'h0800_0040;
        tick();
        chk("b_pc",  b_pc, 32'hF000_0020);
        chk("b_pc4", b_pc4, 32'hF000_0024);
        b_jump = 1'b1;
        tick();
        chk("b_j_addr", b_if.imem_addr, 32'hF000_0100);
        b_branch = 1'b1; b_zero = 1'b1;
        tick();
        tick();
        chk("b_jwin_addr", b_if.imem_addr, 32'hF000_0100);

        // Jump with Branch unknown to the last word, then wrap sequentially
        b_if.imem_rdata = 32'h0BFF_FFFF; b_branch = 1'bx;
        tick();
        tick();
        chk("b_jx_addr", b_if.imem_addr, 32'hFFFF_FFFC);
        b_jump = 1'b0; b_branch = 1'b0; b_zero = 1'b0; b_if.imem_rdata = 32'h0000_0020;
        tick();
        chk("b_wrap_pc",  b_pc, 32'hFFFF_FFFC);
        chk("b_wrap_pc4", b_pc4, 32'h0000_0000);
        tick();
        chk("b_wrap_addr", b_if.imem_addr, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
